// File: rtl/ft600_bus_scheduler_pkg.sv
// Shared types and constants for the FT600 245-sync-FIFO bus scheduler.
package ft600_pkg;

    localparam int FT_DATA_W = 16;
    localparam int FT_BE_W   = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_TURN,
        RD_BURST,
        RD_END,
        WR_BURST,
        WR_END
    } bus_state_t;

    typedef enum logic {
        READ,
        WRITE
    } dir_t;

endpackage

// File: rtl/ft600_bus_scheduler_if.sv
// FT600 pin-side bundle: the scheduler uses the master modport, the chip or bus model uses the slave modport.
interface ft600_bus_if;

    logic                            ftdi_rxf_n;
    logic                            ftdi_txe_n;
    logic                            ftdi_oe_n;
    logic                            ftdi_rd_n;
    logic                            ftdi_wr_n;
    logic [ft600_pkg::FT_DATA_W-1:0] ftdi_data_i;
    logic [ft600_pkg::FT_BE_W-1:0]   ftdi_be_i;
    logic [ft600_pkg::FT_DATA_W-1:0] ftdi_data_o;
    logic [ft600_pkg::FT_BE_W-1:0]   ftdi_be_o;
    logic                            ftdi_drive;

    modport master (
        input  ftdi_rxf_n, ftdi_txe_n, ftdi_data_i, ftdi_be_i,
        output ftdi_oe_n, ftdi_rd_n, ftdi_wr_n, ftdi_data_o, ftdi_be_o, ftdi_drive
    );

    modport slave (
        output ftdi_rxf_n, ftdi_txe_n, ftdi_data_i, ftdi_be_i,
        input  ftdi_oe_n, ftdi_rd_n, ftdi_wr_n, ftdi_data_o, ftdi_be_o, ftdi_drive
    );

endinterface

// File: rtl/ft600_bus_scheduler_rr_arbiter.sv
// Round-robin picker: grants the requester closest at or after ptr, wrapping modulo N.
module ft600_rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    int off;
    int best_off;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        grant    = '0;
        off      = 0;
        best_off = N;
        for (int i = 0; i < N; i++) begin
            off = (i + N - int'(ptr)) % N;
            if (req[i] && (off < best_off)) best_off = off;
        end
        for (int i = 0; i < N; i++) begin
            off      = (i + N - int'(ptr)) % N;
            grant[i] = req[i] && (off == best_off);
        end
    end

endmodule

// File: rtl/ft600_bus_scheduler.sv
// FT600 bus owner: arbitrates read bursts against round-robin write bursts from NUM_TX streams.
// Optional FT_BUS_STATS_EN adds word and turnaround counters.
module ft600_bus_scheduler
    import ft600_pkg::*;
#(
    parameter int NUM_TX    = 2,
    parameter int MAX_BURST = 256
) (
    input  logic                          ftdi_clk,
    input  logic                          rst_n,
    ft600_bus_if.master                   bus,
    output logic [FT_DATA_W-1:0]          rx_data,
    output logic [FT_BE_W-1:0]            rx_be,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    input  logic [NUM_TX-1:0]             tx_valid,
    input  logic [FT_DATA_W*NUM_TX-1:0]   tx_data,
    input  logic [FT_BE_W*NUM_TX-1:0]     tx_be,
    output logic [NUM_TX-1:0]             tx_ready,
    output logic [NUM_TX-1:0]             tx_grant
`ifdef FT_BUS_STATS_EN
    ,
    output logic [31:0]                   stat_rx_words,
    output logic [31:0]                   stat_tx_words,
    output logic [15:0]                   stat_turnarounds
`endif
);

    localparam int PW = (NUM_TX > 1) ? $clog2(NUM_TX) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_C  = CW'(MAX_BURST);
    localparam logic [CW-1:0] LAST_C = CW'(MAX_BURST - 1);

    bus_state_t           state, state_nx;
    dir_t                 last_dir;
    logic [PW-1:0]        rr_ptr, grant_idx;
    logic [NUM_TX-1:0]    grant_q, arb_grant;
    logic [CW-1:0]        burst_cnt;
    logic                 idle_q;
    logic [FT_DATA_W-1:0] data_q, g_data;
    logic [FT_BE_W-1:0]   be_q, g_be;
    logic                 g_valid, rd_req, wr_req, rd_cap, wr_acc;

    ft600_rr_arbiter #(.N(NUM_TX), .PW(PW)) u_arb (
        .req   (tx_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant)
    );

    always_comb begin
        g_valid   = 1'b0;
        g_data    = '0;
        g_be      = '0;
        grant_idx = '0;
        for (int i = 0; i < NUM_TX; i++) begin
            if (grant_q[i]) begin
                g_valid   = tx_valid[i];
                g_data    = tx_data[FT_DATA_W*i +: FT_DATA_W];
                g_be      = tx_be[FT_BE_W*i +: FT_BE_W];
                grant_idx = PW'(i);
            end
        end
    end

    assign rd_req = !bus.ftdi_rxf_n && rx_ready;
    assign wr_req = !bus.ftdi_txe_n && (|tx_valid);
    assign rd_cap = (state == RD_BURST) && !bus.ftdi_rxf_n && (bus.ftdi_be_i != '0);
    assign wr_acc = (state == WR_BURST) && g_valid && !bus.ftdi_txe_n;

    // Pin strobes decode from registered state, so an async reset releases the bus at once.
    assign bus.ftdi_oe_n   = !((state == RD_TURN) || (state == RD_BURST));
    assign bus.ftdi_rd_n   = (state != RD_BURST);
    assign bus.ftdi_wr_n   = !wr_acc;
    assign bus.ftdi_drive  = (state == WR_BURST);
    assign bus.ftdi_data_o = wr_acc ? g_data : data_q;
    assign bus.ftdi_be_o   = wr_acc ? g_be : be_q;
    assign tx_ready        = wr_acc ? grant_q : '0;
    assign tx_grant        = (state == WR_BURST) ? grant_q : '0;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (rd_req && (!wr_req || (last_dir == WRITE))) state_nx = RD_TURN;
                else if (wr_req)                                 state_nx = WR_BURST;
            end
            RD_TURN:  state_nx = RD_BURST;
            RD_BURST: begin
                if (bus.ftdi_rxf_n || !rx_ready || (rd_cap && (burst_cnt == LAST_C)))
                    state_nx = RD_END;
            end
            RD_END:   state_nx = IDLE;
            WR_BURST: begin
                if (bus.ftdi_txe_n || (!g_valid && idle_q) || (wr_acc && (burst_cnt == LAST_C)))
                    state_nx = WR_END;
            end
            WR_END:   state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ftdi_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_dir  <= WRITE;
            rr_ptr    <= '0;
            grant_q   <= '0;
            burst_cnt <= '0;
            idle_q    <= 1'b0;
            data_q    <= '0;
            be_q      <= '0;
            rx_data   <= '0;
            rx_be     <= '0;
            rx_valid  <= 1'b0;
        end else begin
            state    <= state_nx;
            rx_valid <= rd_cap;
            if (rd_cap) begin
                rx_be   <= bus.ftdi_be_i;
                rx_data <= {bus.ftdi_be_i[1] ? bus.ftdi_data_i[15:8] : 8'h00,
                            bus.ftdi_be_i[0] ? bus.ftdi_data_i[7:0]  : 8'h00};
            end
            if (wr_acc) begin
                data_q <= g_data;
                be_q   <= g_be;
            end
            if (state == IDLE) begin
                burst_cnt <= '0;
                idle_q    <= 1'b0;
                if (state_nx == WR_BURST) grant_q <= arb_grant;
            end else if ((rd_cap || wr_acc) && (burst_cnt != MAX_C)) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
            if (state == WR_BURST) idle_q <= !g_valid;
            if (state == RD_END) last_dir <= READ;
            if (state == WR_END) begin
                last_dir <= WRITE;
                grant_q  <= '0;
                rr_ptr   <= (grant_idx == PW'(NUM_TX - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

`ifdef FT_BUS_STATS_EN
    always_ff @(posedge ftdi_clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rx_words    <= '0;
            stat_tx_words    <= '0;
            stat_turnarounds <= '0;
        end else begin
            if (rd_cap) stat_rx_words <= stat_rx_words + 1'b1;
            if (wr_acc) stat_tx_words <= stat_tx_words + 1'b1;
            if ((state == RD_END) || (state == WR_END)) stat_turnarounds <= stat_turnarounds + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ft600_bus_scheduler.sv
// Scoreboard bench for ft600_bus_scheduler: FT600 host model, two requester streams, burst logs.
module tb_ft600_bus_scheduler;

    localparam int NUM_TX = 2;
    localparam int MAXB   = 4;

    logic                 ftdi_clk = 1'b0;
    logic                 rst_n;
    logic [15:0]          rx_data;
    logic [1:0]           rx_be;
    logic                 rx_valid;
    logic                 rx_ready;
    logic [NUM_TX-1:0]    tx_valid;
    logic [16*NUM_TX-1:0] tx_data;
    logic [2*NUM_TX-1:0]  tx_be;
    logic [NUM_TX-1:0]    tx_ready;
    logic [NUM_TX-1:0]    tx_grant;
`ifdef FT_BUS_STATS_EN
    logic [31:0]          stat_rx_words, stat_tx_words;
    logic [15:0]          stat_turnarounds;
`endif

    ft600_bus_if bus();

    ft600_bus_scheduler #(.NUM_TX(NUM_TX), .MAX_BURST(MAXB)) dut (
        .ftdi_clk (ftdi_clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .rx_data  (rx_data),
        .rx_be    (rx_be),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_be    (tx_be),
        .tx_ready (tx_ready),
        .tx_grant (tx_grant)
`ifdef FT_BUS_STATS_EN
        ,
        .stat_rx_words    (stat_rx_words),
        .stat_tx_words    (stat_tx_words),
        .stat_turnarounds (stat_turnarounds)
`endif
    );

    always #5 ftdi_clk = ~ftdi_clk;

    int total = 0;
    int bad   = 0;

    // Words are {be[1:0], data[15:0]}.
    logic [17:0] host_q[$];
    logic [17:0] src0_q[$];
    logic [17:0] src1_q[$];
    logic [17:0] rx_exp_q[$];
    int          burst_log[$];
    int          wlen_log[$];

    int host_stall = 0, txe_stall = 0, bubble = 0, rxr_stall = 0;
    logic cap_prev = 1'b0, prev_oe = 1'b1;
    logic [NUM_TX-1:0] prev_grant = '0;
    int rd_len = 0, wr_len = 0, rx_count = 0, tx_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] ref_mask(input logic [17:0] w);
        return {w[17:16], w[17] ? w[15:8] : 8'h00, w[16] ? w[7:0] : 8'h00};
    endfunction

    // Inputs change just after each rising edge, from the model queues.
    always begin
        @(posedge ftdi_clk);
        #1;
        bus.ftdi_rxf_n = (host_q.size() == 0) || (int'($urandom_range(99)) < host_stall);
        if (host_q.size() != 0) begin
            bus.ftdi_data_i = host_q[0][15:0];
            bus.ftdi_be_i   = host_q[0][17:16];
        end else begin
            bus.ftdi_data_i = 16'($urandom);
            bus.ftdi_be_i   = 2'($urandom_range(3));
        end
        bus.ftdi_txe_n = (int'($urandom_range(99)) < txe_stall);
        rx_ready       = !(int'($urandom_range(99)) < rxr_stall);
        tx_valid[0] = (src0_q.size() != 0) && (int'($urandom_range(99)) >= bubble);
        tx_valid[1] = (src1_q.size() != 0) && (int'($urandom_range(99)) >= bubble);
        {tx_be[1:0], tx_data[15:0]}  = tx_valid[0] ? src0_q[0] : 18'($urandom);
        {tx_be[3:2], tx_data[31:16]} = tx_valid[1] ? src1_q[0] : 18'($urandom);
    end

    logic [17:0] mw;
    logic        acc, cap_now;
    int          g;

    // Monitor: outputs are settled at the falling edge; events complete at the next rising edge.
    always @(negedge ftdi_clk) begin
        if (rst_n) begin
            check("rx_valid_latency", rx_valid, cap_prev);
            if (rx_valid) begin
                if (rx_exp_q.size() == 0) check("rx_unexpected", 1, 0);
                else begin
                    mw = rx_exp_q.pop_front();
                    check("rx_word", {rx_be, rx_data}, mw);
                    rx_count++;
                end
            end
            cap_now = !bus.ftdi_rd_n && !bus.ftdi_rxf_n && (bus.ftdi_be_i != 2'b00);
            if (cap_now) begin
                mw = host_q.pop_front();
                rx_exp_q.push_back(ref_mask(mw));
                rd_len++;
            end
            cap_prev = cap_now;
            check("rd_without_oe", !bus.ftdi_rd_n && bus.ftdi_oe_n, 0);
            check("oe_drive_excl", !bus.ftdi_oe_n && bus.ftdi_drive, 0);
            if (!bus.ftdi_oe_n && prev_oe) burst_log.push_back(2);
            if (bus.ftdi_oe_n && !prev_oe) begin
                check("rd_burst_len_max", rd_len <= MAXB, 1);
                rd_len = 0;
            end
            acc = !bus.ftdi_wr_n && !bus.ftdi_txe_n;
            check("tx_ready", tx_ready, acc ? tx_grant : 2'b00);
            if (!bus.ftdi_wr_n) check("wr_needs_drive", bus.ftdi_drive, 1);
            if (tx_grant == '0) check("drive_without_grant", bus.ftdi_drive, 0);
            if (acc) begin
                check("grant_onehot", $onehot(tx_grant), 1);
                g = tx_grant[1] ? 1 : 0;
                check("wr_valid", tx_valid[g], 1);
                if ((g == 0 && src0_q.size() == 0) || (g == 1 && src1_q.size() == 0))
                    check("wr_source_empty", 1, 0);
                else begin
                    mw = (g == 1) ? src1_q.pop_front() : src0_q.pop_front();
                    check("wr_word", {bus.ftdi_be_o, bus.ftdi_data_o}, mw);
                end
                wr_len++;
                tx_count++;
            end
            if (tx_grant != '0 && prev_grant == '0) burst_log.push_back(tx_grant[1] ? 1 : 0);
            if (tx_grant == '0 && prev_grant != '0) begin
                wlen_log.push_back(wr_len);
                check("wr_burst_len_max", wr_len <= MAXB, 1);
                wr_len = 0;
            end
            prev_oe    = bus.ftdi_oe_n;
            prev_grant = tx_grant;
        end
    end

    task automatic clear_models();
        host_q.delete(); src0_q.delete(); src1_q.delete(); rx_exp_q.delete();
        burst_log.delete(); wlen_log.delete();
        cap_prev = 1'b0; prev_oe = 1'b1; prev_grant = '0; rd_len = 0; wr_len = 0;
    endtask

    task automatic do_reset();
        @(posedge ftdi_clk);
        #3 rst_n = 1'b0;
        clear_models();
        repeat (2) @(posedge ftdi_clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic wait_drained(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget && !(host_q.size() == 0 && src0_q.size() == 0 && src1_q.size() == 0 &&
                               rx_exp_q.size() == 0 && tx_grant == '0 && bus.ftdi_oe_n)) begin
            @(negedge ftdi_clk);
            n++;
        end
        repeat (3) @(negedge ftdi_clk);
        check(name, (host_q.size() == 0 && src0_q.size() == 0 && src1_q.size() == 0 &&
                     rx_exp_q.size() == 0), 1);
    endtask

    int n, rx0, tx0;
    int exp_seq[8] = '{2, 0, 2, 1, 2, 0, 2, 1};
    int exp_len[3] = '{4, 4, 2};

    initial begin
        rst_n = 1'b0;
        bus.ftdi_rxf_n = 1'b1; bus.ftdi_txe_n = 1'b1;
        bus.ftdi_data_i = '0;  bus.ftdi_be_i = '0;
        rx_ready = 1'b1; tx_valid = '0; tx_data = '0; tx_be = '0;
        #1;
        check("rst_oe_n", bus.ftdi_oe_n, 1);
        check("rst_rd_n", bus.ftdi_rd_n, 1);
        check("rst_wr_n", bus.ftdi_wr_n, 1);
        check("rst_drive", bus.ftdi_drive, 0);
        check("rst_data_o", {bus.ftdi_be_o, bus.ftdi_data_o}, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_tx_grant", tx_grant, 0);
        repeat (3) @(posedge ftdi_clk);
        #3 rst_n = 1'b1;

        // Read burst A1..A4 with full byte enables.
        rx0 = rx_count;
        for (int i = 1; i <= 4; i++) host_q.push_back({2'b11, 16'hA000 + 16'(i)});
        n = 0;
        while (bus.ftdi_oe_n && n < 50) begin @(negedge ftdi_clk); n++; end
        check("rd_oe_seen", bus.ftdi_oe_n, 0);
        check("rd_turnaround_rd_n_high", bus.ftdi_rd_n, 1);
        @(negedge ftdi_clk);
        check("rd_rd_n_low_after_turn", bus.ftdi_rd_n, 0);
        wait_drained("rd_drain", 100);
        check("rd_pulse_count", rx_count - rx0, 4);

        // Three-word write from stream 0.
        tx0 = tx_count;
        for (int i = 0; i < 3; i++) src0_q.push_back({2'b11, 16'($urandom)});
        n = 0;
        while (tx_grant == '0 && n < 50) begin @(negedge ftdi_clk); n++; end
        check("wr_grant_stream0", tx_grant, 2'b01);
        wait_drained("wr_drain", 100);
        check("wr_accept_count", tx_count - tx0, 3);
        check("wr_burst_len", (wlen_log.size() != 0) ? wlen_log[wlen_log.size()-1] : -1, 3);

        // Both directions continuously pending: R, W0, R, W1 ...
        do_reset();
        for (int i = 0; i < 16; i++) host_q.push_back({2'($urandom_range(1, 3)), 16'($urandom)});
        for (int i = 0; i < 8; i++) begin
            src0_q.push_back({2'b11, 16'($urandom)});
            src1_q.push_back({2'b11, 16'($urandom)});
        end
        wait_drained("alt_drain", 400);
        check("alt_burst_count", burst_log.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("alt_burst_%0d", i), (i < burst_log.size()) ? burst_log[i] : -1, exp_seq[i]);

        // Ten words on one stream split at MAX_BURST.
        do_reset();
        for (int i = 0; i < 10; i++) src0_q.push_back({2'b11, 16'($urandom)});
        wait_drained("max_drain", 200);
        check("max_burst_count", wlen_log.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("max_burst_len_%0d", i), (i < wlen_log.size()) ? wlen_log[i] : -1, exp_len[i]);

        // Low byte only: upper byte forced to zero.
`ifdef FT_BUS_STATS_EN
        rx0 = int'(stat_rx_words);
`endif
        host_q.push_back({2'b01, 16'hBEEF});
        n = 0;
        while (!rx_valid && n < 50) begin @(negedge ftdi_clk); n++; end
        check("be01_rx_data", rx_data, 16'h00EF);
        check("be01_rx_be", rx_be, 2'b01);
        wait_drained("be01_drain", 50);
`ifdef FT_BUS_STATS_EN
        check("stat_rx_words_inc", int'(stat_rx_words) - rx0, 1);
`endif

        // Randomized traffic with stalls and bubbles.
        host_stall = 20; txe_stall = 10; bubble = 25; rxr_stall = 10;
        for (int c = 0; c < 3000; c++) begin
            @(negedge ftdi_clk);
            #1;
            if (host_q.size() < 8 && $urandom_range(99) < 40)
                host_q.push_back({2'($urandom_range(1, 3)), 16'($urandom)});
            if (src0_q.size() < 8 && $urandom_range(99) < 30) src0_q.push_back(18'($urandom));
            if (src1_q.size() < 8 && $urandom_range(99) < 30) src1_q.push_back(18'($urandom));
        end
        host_stall = 0; txe_stall = 0; bubble = 0; rxr_stall = 0;
        wait_drained("random_drain", 3000);

        // Reset in the middle of a write burst.
        for (int i = 0; i < 10; i++) src0_q.push_back({2'b11, 16'($urandom)});
        n = 0;
        while (!(tx_grant != '0 && wr_len >= 2) && n < 100) begin @(negedge ftdi_clk); n++; end
        check("midrst_in_burst", bus.ftdi_drive, 1);
        @(posedge ftdi_clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_drive", bus.ftdi_drive, 0);
        check("midrst_wr_n", bus.ftdi_wr_n, 1);
        check("midrst_tx_ready", tx_ready, 0);
        check("midrst_tx_grant", tx_grant, 0);
        clear_models();
        repeat (2) @(posedge ftdi_clk);
        #3 rst_n = 1'b1;
        repeat (3) @(negedge ftdi_clk);
        check("post_rst_idle", {bus.ftdi_oe_n, bus.ftdi_rd_n, bus.ftdi_wr_n, bus.ftdi_drive, tx_grant},
              {1'b1, 1'b1, 1'b1, 1'b0, 2'b00});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
